// File: rtl/pad10_1_strip.sv
// Strips single-block pad10*1 padding from a final rate block and reports the message length.
// Define PAD10_1_STRIP_FAST_EN to resolve the whole block in CHECK with a priority encoder instead of scanning.
module pad10_1_strip #(
  parameter int R_BITS = 8,
  parameter int LEN_W  = $clog2(R_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [R_BITS-1:0] block,
  output logic [LEN_W-1:0]  msg_len,
  output logic              pad_ok,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [R_BITS-1:0] blk_q, blk_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ok_q, ok_d;

`ifdef PAD10_1_STRIP_FAST_EN
  logic              enc_hit;
  logic [LEN_W-1:0]  enc_idx;

  // Later iterations overwrite earlier ones, so the highest set bit below the final 1 wins.
  always_comb begin
    enc_hit = 1'b0;
    enc_idx = '0;
    for (int i = 0; i < R_BITS - 1; i++) begin
      if (blk_q[i]) begin
        enc_hit = 1'b1;
        enc_idx = LEN_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ok_d    = ok_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_d   = block;
          ok_d    = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!blk_q[R_BITS-1]) begin
          ok_d    = 1'b0;
          len_d   = '0;
          state_d = S_DONE;
        end else begin
`ifdef PAD10_1_STRIP_FAST_EN
          ok_d    = enc_hit;
          len_d   = enc_hit ? enc_idx : '0;
          state_d = S_DONE;
`else
          idx_d   = LEN_W'(R_BITS - 2);
          state_d = S_SCAN;
`endif
        end
      end
`ifndef PAD10_1_STRIP_FAST_EN
      S_SCAN: begin
        if (blk_q[idx_q]) begin
          len_d   = idx_q;
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          // Reached bit 0 without finding the leading pad 1: malformed padding.
          len_d   = '0;
          ok_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - LEN_W'(1);
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ok_q    <= ok_d;
    end
  end

  assign msg_len = len_q;
  assign pad_ok  = ok_q;
  assign busy    = (state_q == S_CHECK) || (state_q == S_SCAN);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_pad10_1_strip.sv
// Directed and randomized checks of pad10_1_strip (R_BITS = 8) against a rule-level reference model.
module tb_pad10_1_strip;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] block;
  logic [2:0] msg_len;
  logic       pad_ok;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  pad10_1_strip #(.R_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .block   (block),
    .msg_len (msg_len),
    .pad_ok  (pad_ok),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Message is everything below the highest 1 under the top bit; the top bit must be the final pad 1.
  task automatic model(input logic [7:0] b, output int len, output int ok, output int lat);
    int hi;
    hi = -1;
    for (int i = 6; i >= 0; i--) begin
      if (b[i] && hi < 0) hi = i;
    end
    if (!b[7]) begin
      len = 0; ok = 0; lat = 1;
    end else if (hi < 0) begin
      len = 0; ok = 0; lat = 8;
    end else begin
      len = hi; ok = 1; lat = 8 - hi;
    end
`ifdef PAD10_1_STRIP_FAST_EN
    lat = 1;
`endif
  endtask

  task automatic run_op(input logic [7:0] b, input string tag);
    int elen, eok, elat;
    int got_lat, bcount;
    model(b, elen, eok, elat);
    @(negedge clk);
    start = 1'b1;
    block = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_okclr"}, 32'(pad_ok), 32'd0);
    got_lat = -1;
    bcount  = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        got_lat = k;
        break;
      end
      if (busy === 1'b1) bcount++;
    end
    check({tag, "_lat"}, 32'(got_lat), 32'(elat));
    check({tag, "_busy"}, 32'(bcount), 32'(elat));
    check({tag, "_len"}, 32'(msg_len), 32'(elen));
    check({tag, "_ok"}, 32'(pad_ok), 32'(eok));
    @(posedge clk);
    #1;
    check({tag, "_done1"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_lenhold"}, 32'(msg_len), 32'(elen));
    check({tag, "_okhold"}, 32'(pad_ok), 32'(eok));
  endtask

  initial begin
    int ndone, first_done;
    logic [7:0] rb;

    rst_n = 1'b0;
    start = 1'b1;
    block = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_len", 32'(msg_len), 32'd0);
    check("rst_ok", 32'(pad_ok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    run_op(8'b1000_0101, "m2");
    run_op(8'b1100_0000, "m6");
    run_op(8'b1000_0001, "m0");
    run_op(8'b0000_0101, "notop");
    run_op(8'b1000_0000, "nolow");

    // start held high with a changing block while busy must not disturb the result
    @(negedge clk);
    start = 1'b1;
    block = 8'b1000_0101;
    @(posedge clk);
    #1;
    ndone = 0;
    first_done = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 1) block = 8'hFF;
      if (done === 1'b1) begin
        ndone++;
        first_done = k;
        break;
      end
    end
`ifdef PAD10_1_STRIP_FAST_EN
    check("hold_lat", 32'(first_done), 32'd1);
`else
    check("hold_lat", 32'(first_done), 32'd6);
`endif
    check("hold_len", 32'(msg_len), 32'd2);
    check("hold_ok", 32'(pad_ok), 32'd1);
    @(posedge clk);
    #1;
    check("hold_idle", 32'(busy), 32'd0);
    check("hold_done_once", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    first_done = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done === 1'b1) begin
        first_done = k;
        break;
      end
    end
`ifdef PAD10_1_STRIP_FAST_EN
    check("ff_lat", 32'(first_done), 32'd1);
`else
    check("ff_lat", 32'(first_done), 32'd2);
`endif
    check("ff_len", 32'(msg_len), 32'd6);
    check("ff_ok", 32'(pad_ok), 32'd1);

    // reset mid-operation aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    block = 8'b1000_0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_len", 32'(msg_len), 32'd0);
    check("abort_ok", 32'(pad_ok), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort_nodone", 32'(ndone), 32'd0);
    run_op(8'b1010_0000, "post_rst");

    for (int t = 0; t < 40; t++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rb[7] = 1'b1;
      if ($urandom_range(0, 2) == 0) rb = rb & 8'($urandom);
      run_op(rb, $sformatf("rnd%0d_%02h", t, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
